dc_stage: RTL

//  Memory-access (DC) pipeline stage, directly downstream of EX. Latches ex_to_dc_bus and

---
 rtl/dc_stage_pkg.sv | 42 ++++
 rtl/dc_stage_load_ext.sv | 28 ++
 rtl/dc_stage.sv | 77 +++++++
 3 files changed

// File: rtl/dc_stage_pkg.sv
// Shared definitions for the DC (memory-access) pipeline stage.
//  - Bus widths for EX->DC, DC->WB and DC->RF (forwarding).
//  - Stall encoding: a stall bit of STOP freezes that pipeline register.
//  - ex_to_dc_t mirrors the packed layout of ex_to_dc_bus.
//  - Bit positions of the individual memory ops within mem_op.
package dc_stage_pkg;

  localparam int EX_TO_DC_WD  = 151;
  localparam int DC_TO_WB_WD  = 136;
  localparam int DC_TO_RF_WD  = 104;
  localparam int HILO_WD      = 66;
  localparam int STALL_BUS_WD = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // mem_op = {lb, lbu, lh, lhu, lw, sb, sh, sw}
  localparam int MOP_LB  = 7;
  localparam int MOP_LBU = 6;
  localparam int MOP_LH  = 5;
  localparam int MOP_LHU = 4;
  localparam int MOP_LW  = 3;

  typedef struct packed {
    logic [7:0]         mem_op;      // [150:143]
    logic [HILO_WD-1:0] hilo_bus;    // [142:77]
    logic [31:0]        pc;          // [76:45]
    logic               ram_en;      // [44]
    logic               ram_wen;     // [43]
    logic [3:0]         ram_sel;     // [42:39]
    logic               sel_rf_res;  // [38]
    logic               rf_we;       // [37]
    logic [4:0]         rf_waddr;    // [36:32]
    logic [31:0]        ex_result;   // [31:0]
  } ex_to_dc_t;

  // True when any of the five load ops is set.
  function automatic logic is_load(input logic [7:0] mem_op);
    return |mem_op[MOP_LB:MOP_LW];
  endfunction

endpackage

// File: rtl/dc_stage_load_ext.sv
// Load alignment and extension.
//  mem_op  in  5   {lb, lbu, lh, lhu, lw}
//  addr    in  2   low address bits (byte offset within the word)
//  rdata   in  32  raw SRAM word
//  result  out 32  aligned, sign/zero extended load value (0 when no load op)
// Misaligned half/word addresses are not trapped; low bits are simply ignored.
module dc_stage_load_ext (
  input  logic [4:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[8*addr +: 8];
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    result = 32'h0;
    if (mem_op[4])      result = {{24{byte_v[7]}}, byte_v};   // lb
    else if (mem_op[3]) result = {24'h0, byte_v};             // lbu
    else if (mem_op[2]) result = {{16{half_v[15]}}, half_v};  // lh
    else if (mem_op[1]) result = {16'h0, half_v};             // lhu
    else if (mem_op[0]) result = rdata;                       // lw
  end

endmodule

// File: rtl/dc_stage.sv
// DC (memory-access) pipeline stage, directly downstream of EX.
//  clk, rst         clock; synchronous active-high reset
//  stall            stall[3] freezes EX->DC register, stall[4] freezes DC->WB register
//  ex_to_dc_bus     instruction bus from EX
//  data_sram_rdata  SRAM read data, valid in the first cycle a load sits in DC
//  dc_to_wb_bus     {hilo_bus, pc, rf_we, rf_waddr, rf_wdata} to WB
//  dc_to_rf_bus     {hilo_bus, rf_we, rf_waddr, rf_wdata} forwarding to ID
// The SRAM only presents read data for one cycle, so a load held in DC by a
// downstream stall keeps its first-cycle data in rdata_hold.
module dc_stage
  import dc_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [DC_TO_WB_WD-1:0]  dc_to_wb_bus,
  output logic [DC_TO_RF_WD-1:0]  dc_to_rf_bus
);

  ex_to_dc_t   bus_r;
  logic [31:0] rdata_hold;
  logic        hold_v;

  logic        bubble;
  logic        advance;
  logic        bus_wr;
  logic [31:0] ld_raw;
  logic [31:0] load_result;
  logic        use_load;
  logic [31:0] rf_wdata;

  // EX frozen while WB side moves on: insert a bubble so the instruction
  // in DC is not committed twice.
  assign bubble  = (stall[3] == STOP) && (stall[4] == NO_STOP);
  assign advance = (stall[3] == NO_STOP);
  assign bus_wr  = bubble || advance;

  always_ff @(posedge clk) begin
    if (rst)          bus_r <= '0;
    else if (bubble)  bus_r <= '0;
    else if (advance) bus_r <= ex_to_dc_bus;
  end

  // Capture only on the first stalled cycle; later cycles keep that word.
  always_ff @(posedge clk) begin
    if (rst || bus_wr) begin
      hold_v <= 1'b0;
    end else if (!hold_v && (stall[4] == STOP)) begin
      rdata_hold <= data_sram_rdata;
      hold_v     <= 1'b1;
    end
  end

  assign ld_raw = hold_v ? rdata_hold : data_sram_rdata;

  dc_stage_load_ext u_load_ext (
    .mem_op (bus_r.mem_op[MOP_LB:MOP_LW]),
    .addr   (bus_r.ex_result[1:0]),
    .rdata  (ld_raw),
    .result (load_result)
  );

  // Stores, non-writing loads and bubbles all pass ex_result through.
  assign use_load = bus_r.sel_rf_res && bus_r.rf_we && is_load(bus_r.mem_op);
  assign rf_wdata = use_load ? load_result : bus_r.ex_result;

  assign dc_to_wb_bus = {bus_r.hilo_bus, bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, rf_wdata};
  assign dc_to_rf_bus = {bus_r.hilo_bus, bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

  // Fields consumed elsewhere (EX drives the SRAM request) or not used here.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus_r.ram_en, bus_r.ram_wen, bus_r.ram_sel,
                       bus_r.mem_op[2:0], stall[5], stall[2:0]};

endmodule
